// File: rtl/bldc_pkg.sv
// Shared types and helpers for the six-step BLDC commutator: sector codes, FSM states and the
// commutation tables.
package bldc_pkg;

    localparam logic [2:0] SEC_A       = 3'd0;
    localparam logic [2:0] SEC_B       = 3'd1;
    localparam logic [2:0] SEC_C       = 3'd2;
    localparam logic [2:0] SEC_D       = 3'd3;
    localparam logic [2:0] SEC_E       = 3'd4;
    localparam logic [2:0] SEC_F       = 3'd5;
    localparam logic [2:0] SEC_INVALID = 3'd7;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StDead  = 2'd1,
        StDrive = 2'd2
    } fsm_state_e;

    // {ghC, ghB, ghA, glC, glB, glA}
    typedef logic [5:0] gate_pattern_t;

    localparam gate_pattern_t PAT_OFF      = 6'b000_000;
    localparam gate_pattern_t PAT_BRAKE_LS = 6'b000_111;

    function automatic logic [2:0] hall_decode(input logic [2:0] code);
        logic [2:0] sec;
        case (code)
            3'b101:  sec = SEC_A;
            3'b100:  sec = SEC_B;
            3'b110:  sec = SEC_C;
            3'b010:  sec = SEC_D;
            3'b011:  sec = SEC_E;
            3'b001:  sec = SEC_F;
            default: sec = SEC_INVALID;
        endcase
        return sec;
    endfunction

    // Reverse rotation energises the same phase pair with high and low sides swapped.
    function automatic gate_pattern_t commutation_pattern(input logic [2:0] sec, input logic dir);
        gate_pattern_t fwd;
        case (sec)
            SEC_A:   fwd = 6'b100_010;
            SEC_B:   fwd = 6'b001_010;
            SEC_C:   fwd = 6'b001_100;
            SEC_D:   fwd = 6'b010_100;
            SEC_E:   fwd = 6'b010_001;
            SEC_F:   fwd = 6'b100_001;
            default: fwd = PAT_OFF;
        endcase
        return dir ? fwd : {fwd[2:0], fwd[5:3]};
    endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// Hall input synchroniser and stability filter: a new code is accepted only after HALL_FILTER
// consecutive identical synchronised samples.
module hall_filter #(
    parameter int unsigned HALL_FILTER = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] hall,
    output logic [2:0] sample,
    output logic       accept
);

    logic [2:0] sync1_q, sync2_q;
    logic [2:0] cand_q, acc_q;
    logic [7:0] cnt_q;
    logic [7:0] seen;

    always_comb begin
        seen   = (sync2_q == cand_q) ? cnt_q + 8'd1 : 8'd1;
        accept = (sync2_q != acc_q) && (seen == 8'(HALL_FILTER));
    end

    assign sample = sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cand_q  <= 3'b000;
            acc_q   <= 3'b000;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= hall;
            sync2_q <= sync1_q;
            if (sync2_q == acc_q) begin
                cand_q <= acc_q;
                cnt_q  <= 8'd0;
            end else if (accept) begin
                acc_q  <= sync2_q;
                cand_q <= sync2_q;
                cnt_q  <= 8'd0;
            end else begin
                cand_q <= sync2_q;
                cnt_q  <= seen;
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall decode, target-pattern selection, dead-time FSM, invalid-hall
// fault tracking and a registered, shoot-through-guarded gate output stage.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES   = 1024,
    parameter int unsigned HALL_FILTER   = 4,
    parameter int unsigned INVALID_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       dir,
    input  logic       brake,
    input  logic [2:0] hall,
    input  logic       pwm_in,
    input  logic       fault_n,
    input  logic       clear_fault,
    output logic [2:0] inh,
    output logic [2:0] inl,
    output logic [2:0] sector,
    output logic       dead_active,
    output logic       hall_fault
);

    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES - 1);
    localparam logic [15:0] INV_MAX   = 16'(INVALID_LIMIT);
    localparam logic [15:0] INV_LAST  = 16'(INVALID_LIMIT - 1);

    logic [2:0]    filt_sample;
    logic          filt_accept;
    logic [2:0]    sector_q;
    logic          fault_s1_q, fault_s2_q;
    logic [15:0]   inv_cnt_q;
    logic          hall_fault_q;
    fsm_state_e    state_q, state_d;
    logic [15:0]   dead_cnt_q, dead_cnt_d;
    gate_pattern_t tgt_q, tgt_d;
    gate_pattern_t gates_q, gates_d;
    gate_pattern_t target;
    gate_pattern_t drive;

    hall_filter #(
        .HALL_FILTER(HALL_FILTER)
    ) u_hall_filter (
        .clk    (clk),
        .reset_n(reset_n),
        .hall   (hall),
        .sample (filt_sample),
        .accept (filt_accept)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sector_q     <= SEC_INVALID;
            fault_s1_q   <= 1'b0;
            fault_s2_q   <= 1'b0;
            inv_cnt_q    <= 16'd0;
            hall_fault_q <= 1'b0;
        end else begin
            fault_s1_q <= fault_n;
            fault_s2_q <= fault_s1_q;
            if (filt_accept) begin
                sector_q <= hall_decode(filt_sample);
            end
            // A clear can only take effect on a valid sector, so a same-cycle set always wins.
            if (sector_q == SEC_INVALID) begin
                if (inv_cnt_q < INV_MAX) begin
                    inv_cnt_q <= inv_cnt_q + 16'd1;
                end
                if (inv_cnt_q >= INV_LAST) begin
                    hall_fault_q <= 1'b1;
                end
            end else begin
                inv_cnt_q <= 16'd0;
                if (clear_fault) begin
                    hall_fault_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        target = PAT_OFF;
        if (!enable || hall_fault_q || !fault_s2_q || sector_q == SEC_INVALID) begin
            target = PAT_OFF;
        end else if (brake) begin
            target = PAT_BRAKE_LS;
        end else begin
            target = commutation_pattern(sector_q, dir);
        end
    end

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        tgt_d      = tgt_q;
        unique case (state_q)
            StOff: begin
                if (target != PAT_OFF) begin
                    state_d    = StDead;
                    dead_cnt_d = DEAD_LOAD;
                    tgt_d      = target;
                end
            end
            StDead: begin
                if (target == PAT_OFF) begin
                    state_d = StOff;
                end else if (target != tgt_q) begin
                    dead_cnt_d = DEAD_LOAD;
                    tgt_d      = target;
                end else if (dead_cnt_q == 16'd0) begin
                    state_d = StDrive;
                end else begin
                    dead_cnt_d = dead_cnt_q - 16'd1;
                end
            end
            StDrive: begin
                if (target == PAT_OFF) begin
                    state_d = StOff;
                end else if (target != tgt_q) begin
                    state_d    = StDead;
                    dead_cnt_d = DEAD_LOAD;
                    tgt_d      = target;
                end
            end
            default: state_d = StOff;
        endcase

        drive   = (state_d == StDrive) ? tgt_d : PAT_OFF;
        gates_d = drive;
        for (int i = 0; i < 3; i++) begin
            if (drive[i+3] && drive[i]) begin
                gates_d[i+3] = 1'b0;
                gates_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StOff;
            dead_cnt_q <= 16'd0;
            tgt_q      <= PAT_OFF;
            gates_q    <= PAT_OFF;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            tgt_q      <= tgt_d;
            gates_q    <= gates_d;
        end
    end

    assign inh         = gates_q[5:3] & {3{pwm_in}};
    assign inl         = gates_q[2:0];
    assign sector      = sector_q;
    assign dead_active = (state_q == StDead);
    assign hall_fault  = hall_fault_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator: steady-state table, directed timing sequences and
// randomised commutation events checked against a timeline model.
module tb_bldc_commutator;

    localparam int D  = 1024;
    localparam int F  = 4;
    localparam int IL = 16;
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       reset_n, enable, dir, brake, pwm_in, fault_n, clear_fault;
    logic [2:0] hall;
    logic [2:0] inh, inl, sector;
    logic       dead_active, hall_fault;

    int n_pass = 0;
    int n_total = 0;

    // Phase indices A=0, B=1, C=2 of the high and low side in forward rotation, per sector A..F.
    int         fwd_hi[6] = '{2, 0, 0, 1, 1, 2};
    int         fwd_lo[6] = '{1, 1, 2, 2, 0, 0};
    logic [2:0] hall_of[6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    typedef struct {
        logic [2:0] hall;
        logic       dir;
        logic       brake;
        logic [2:0] inh;
        logic [2:0] inl;
        logic [2:0] sec;
    } vec_t;

    vec_t vecs[13];

    bldc_commutator #(
        .DEAD_CYCLES  (D),
        .HALL_FILTER  (F),
        .INVALID_LIMIT(IL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .dir        (dir),
        .brake      (brake),
        .hall       (hall),
        .pwm_in     (pwm_in),
        .fault_n    (fault_n),
        .clear_fault(clear_fault),
        .inh        (inh),
        .inl        (inl),
        .sector     (sector),
        .dead_active(dead_active),
        .hall_fault (hall_fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            assert ((inh & inl) == 3'b000)
            else $error("FAIL overlap: inh=%b inl=%b required no common phase", inh, inl);
        end
    end

    function automatic logic [5:0] pattern_of(input int sec, input logic d, input logic b);
        int hi, lo;
        if (b) return 6'b000_111;
        hi = d ? fwd_hi[sec] : fwd_lo[sec];
        lo = d ? fwd_lo[sec] : fwd_hi[sec];
        return {3'(1 << hi), 3'(1 << lo)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Gates hold old_pat before off_at, are off until the dead window [dead_at, dead_at+len)
    // has elapsed, then show new_pat; sector switches at sec_at.
    task automatic timeline(input string name, input int n, input logic [5:0] old_pat,
                            input logic [5:0] new_pat, input int off_at, input int dead_at,
                            input int len, input logic [2:0] old_sec, input logic [2:0] new_sec,
                            input int sec_at);
        int errs = 0;
        int first = 0;
        logic [5:0] ep;
        logic       ed;
        logic [2:0] es;
        logic [2:0] a_inh, a_inl, a_sec, r_inh, r_inl, r_sec;
        logic       a_dead, r_dead;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c < off_at) ep = old_pat;
            else if (c < dead_at + len) ep = 6'b000_000;
            else ep = new_pat;
            ed = (c >= dead_at) && (c < dead_at + len);
            es = (c >= sec_at) ? new_sec : old_sec;
            if (inh !== (ep[5:3] & {3{pwm_in}}) || inl !== ep[2:0] || sector !== es ||
                dead_active !== ed) begin
                if (errs == 0) begin
                    first  = c;
                    a_inh  = inh;
                    a_inl  = inl;
                    a_sec  = sector;
                    a_dead = dead_active;
                    r_inh  = ep[5:3] & {3{pwm_in}};
                    r_inl  = ep[2:0];
                    r_sec  = es;
                    r_dead = ed;
                end
                errs++;
            end
            pwm_in = 1'($urandom_range(0, 1));
        end
        n_total++;
        if (errs == 0) n_pass++;
        else $display("FAIL %s: %0d bad cycles, first c=%0d inh=%b inl=%b sec=%0d dead=%b, required inh=%b inl=%b sec=%0d dead=%b",
                      name, errs, first, a_inh, a_inl, a_sec, a_dead, r_inh, r_inl, r_sec,
                      r_dead);
    endtask

    initial begin
        logic [5:0] pat_a, pat_b, pat_brk, rev_a, p_old, p_new;
        int cur_sec, nxt_sec, kind, lag;
        logic cur_dir, nxt_dir, cur_brake, nxt_brake;

        vecs[0]  = '{3'b100, 1'b1, 1'b0, 3'b001, 3'b010, 3'd1};
        vecs[1]  = '{3'b110, 1'b1, 1'b0, 3'b001, 3'b100, 3'd2};
        vecs[2]  = '{3'b010, 1'b1, 1'b0, 3'b010, 3'b100, 3'd3};
        vecs[3]  = '{3'b011, 1'b1, 1'b0, 3'b010, 3'b001, 3'd4};
        vecs[4]  = '{3'b001, 1'b1, 1'b0, 3'b100, 3'b001, 3'd5};
        vecs[5]  = '{3'b001, 1'b0, 1'b0, 3'b001, 3'b100, 3'd5};
        vecs[6]  = '{3'b011, 1'b0, 1'b0, 3'b001, 3'b010, 3'd4};
        vecs[7]  = '{3'b010, 1'b0, 1'b0, 3'b100, 3'b010, 3'd3};
        vecs[8]  = '{3'b110, 1'b0, 1'b0, 3'b100, 3'b001, 3'd2};
        vecs[9]  = '{3'b100, 1'b0, 1'b0, 3'b010, 3'b001, 3'd1};
        vecs[10] = '{3'b101, 1'b0, 1'b0, 3'b010, 3'b100, 3'd0};
        vecs[11] = '{3'b101, 1'b0, 1'b1, 3'b000, 3'b111, 3'd0};
        vecs[12] = '{3'b101, 1'b1, 1'b0, 3'b100, 3'b010, 3'd0};

        pat_a   = pattern_of(0, 1'b1, 1'b0);
        pat_b   = pattern_of(1, 1'b1, 1'b0);
        pat_brk = pattern_of(0, 1'b1, 1'b1);
        rev_a   = pattern_of(0, 1'b0, 1'b0);

        reset_n = 1'b0;
        enable = 1'b1;
        dir = 1'b1;
        brake = 1'b0;
        hall = 3'b101;
        pwm_in = 1'b1;
        fault_n = 1'b1;
        clear_fault = 1'b0;

        repeat (3) tick();
        check("reset_inh", 32'(inh), 0);
        check("reset_inl", 32'(inl), 0);
        check("reset_sector", 32'(sector), 7);
        check("reset_dead", 32'(dead_active), 0);
        check("reset_hall_fault", 32'(hall_fault), 0);
        reset_n = 1'b1;
        timeline("first_drive", 3 + F + D + 2, 6'b0, pat_a, 3 + F, 3 + F, D, 3'd7, 3'd0, 2 + F);

        for (int i = 0; i < 13; i++) begin
            hall = vecs[i].hall;
            dir = vecs[i].dir;
            brake = vecs[i].brake;
            pwm_in = 1'b1;
            repeat (3 + F + D + 8) tick();
            check($sformatf("table%0d_inh", i), 32'(inh), 32'(vecs[i].inh));
            check($sformatf("table%0d_inl", i), 32'(inl), 32'(vecs[i].inl));
            check($sformatf("table%0d_sector", i), 32'(sector), 32'(vecs[i].sec));
        end

        hall = 3'b100;
        timeline("hall_a_to_b", 3 + F + D + 3, pat_a, pat_b, 3 + F, 3 + F, D, 3'd0, 3'd1, 2 + F);
        hall = 3'b101;
        timeline("hall_b_to_a", 3 + F + D + 3, pat_b, pat_a, 3 + F, 3 + F, D, 3'd1, 3'd0, 2 + F);

        hall = 3'b100;
        tick();
        tick();
        hall = 3'b101;
        timeline("hall_glitch", 20, pat_a, pat_a, NEVER, NEVER, D, 3'd0, 3'd0, 0);

        fault_n = 1'b0;
        tick();
        fault_n = 1'b1;
        timeline("fault_pulse", 3 + D + 3, pat_a, pat_a, 2, 3, D, 3'd0, 3'd0, 0);

        hall = 3'b111;
        timeline("invalid_hall", 20, pat_a, 6'b0, 3 + F, NEVER, D, 3'd0, 3'd7, 2 + F);
        tick();
        check("hall_fault_before_limit", 32'(hall_fault), 0);
        tick();
        check("hall_fault_at_limit", 32'(hall_fault), 1);
        check("hall_fault_gates_off", 32'(inl), 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("clear_ignored_invalid", 32'(hall_fault), 1);
        hall = 3'b101;
        repeat (10) tick();
        check("fault_sticky_sector", 32'(sector), 0);
        check("fault_sticky_flag", 32'(hall_fault), 1);
        check("fault_sticky_gates", 32'(inl), 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("fault_cleared", 32'(hall_fault), 0);
        timeline("clear_then_drive", 1 + D + 3, 6'b0, pat_a, 1, 1, D, 3'd0, 3'd0, 0);

        brake = 1'b1;
        timeline("brake_engage", 1 + D + 3, pat_a, pat_brk, 1, 1, D, 3'd0, 3'd0, 0);
        brake = 1'b0;
        timeline("brake_release", 299, pat_brk, pat_a, 1, 1, D, 3'd0, 3'd0, 0);
        dir = 1'b0;
        timeline("dir_flip_mid_dead", D + 4, 6'b0, rev_a, 0, 0, D + 1, 3'd0, 3'd0, 0);

        reset_n = 1'b0;
        #1;
        check("async_reset_inl", 32'(inl), 0);
        check("async_reset_inh", 32'(inh), 0);
        check("async_reset_sector", 32'(sector), 7);
        #1;
        reset_n = 1'b1;
        timeline("reset_mid_drive", 3 + F + D + 3, 6'b0, rev_a, 3 + F, 3 + F, D, 3'd7, 3'd0,
                 2 + F);

        cur_sec = 0;
        cur_dir = 1'b0;
        cur_brake = 1'b0;
        for (int t = 0; t < 16; t++) begin
            nxt_sec = cur_sec;
            nxt_dir = cur_dir;
            nxt_brake = cur_brake;
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                nxt_sec = (cur_sec + int'($urandom_range(1, 5))) % 6;
                lag = 3 + F;
            end else if (kind == 2) begin
                nxt_dir = ~cur_dir;
                lag = 1;
            end else begin
                nxt_brake = ~cur_brake;
                lag = 1;
            end
            hall = hall_of[nxt_sec];
            dir = nxt_dir;
            brake = nxt_brake;
            p_old = pattern_of(cur_sec, cur_dir, cur_brake);
            p_new = pattern_of(nxt_sec, nxt_dir, nxt_brake);
            if (p_old == p_new)
                timeline($sformatf("rand%0d", t), 12, p_old, p_new, NEVER, NEVER, D,
                         3'(cur_sec), 3'(nxt_sec), 2 + F);
            else
                timeline($sformatf("rand%0d", t), lag + D + 3, p_old, p_new, lag, lag, D,
                         3'(cur_sec), 3'(nxt_sec), (kind <= 1) ? 2 + F : 0);
            cur_sec = nxt_sec;
            cur_dir = nxt_dir;
            cur_brake = nxt_brake;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
